// File: rtl/johnson_pkg.sv
// Shared types and constants for the Johnson sequence controller.
package johnson_pkg;

    localparam int PCNT_W = 8;   // prescaler counter width
    localparam int ROT_W  = 8;   // remaining-rotation counter width

    typedef enum logic [2:0] {
        OP_NOP     = 3'd0,
        OP_START   = 3'd1,
        OP_STOP    = 3'd2,
        OP_STEP    = 3'd3,
        OP_SET_DIV = 3'd4,
        OP_SET_DIR = 3'd5,
        OP_CLEAR   = 3'd6,
        OP_RSVD    = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } state_e;

endpackage

// File: rtl/johnson_prescaler.sv
// Divide-by-(div+1) tick generator: counts 0..div while enabled and
// raises tick combinationally in the cycle where the count equals div.
module johnson_prescaler
    import johnson_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [PCNT_W-1:0] div,
    output logic              tick,
    output logic [PCNT_W-1:0] pcnt
);

    logic [PCNT_W-1:0] r_pcnt;

    assign tick = en && (r_pcnt == div);
    assign pcnt = r_pcnt;

    // Count up while enabled; restart after a tick or on an explicit clear.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            r_pcnt <= '0;
        end else if (clr || tick) begin
            r_pcnt <= '0;
        end else if (en) begin
            r_pcnt <= r_pcnt + PCNT_W'(1);
        end
    end

endmodule

// File: rtl/johnson_seq_ctrl.sv
// Command-driven Johnson counter: free or counted runs, single steps,
// programmable advance rate and direction, wrap/done pulses, sticky error.
module johnson_seq_ctrl
    import johnson_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [7:0]       cmd_arg,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             wrap,
    output logic             done,
    output logic             err
);

    state_e            r_state;
    logic [WIDTH-1:0]  r_q;
    logic              r_dir;
    logic [PCNT_W-1:0] r_div;
    logic [ROT_W-1:0]  r_rot_left;
    logic              r_wrap;
    logic              r_done;
    logic              r_err;

    state_e            w_state_nxt;
    logic [WIDTH-1:0]  w_q_nxt;
    logic              w_dir_nxt;
    logic [PCNT_W-1:0] w_div_nxt;
    logic [ROT_W-1:0]  w_rot_nxt;
    logic              w_wrap_nxt;
    logic              w_done_nxt;
    logic              w_err_nxt;
    logic              w_advance;
    logic              w_pclr;
    logic              w_tick;
    logic [PCNT_W-1:0] w_pcnt;
    logic              w_acc;
    op_e               w_op;

    // One Johnson step; down shifts toward bit 0, up shifts toward the MSB.
    function automatic logic [WIDTH-1:0] step_q(input logic [WIDTH-1:0] cur,
                                                input logic             down);
        if (down) return {~cur[0], cur[WIDTH-1:1]};
        return {cur[WIDTH-2:0], ~cur[WIDTH-1]};
    endfunction

    assign w_acc     = cmd_valid && cmd_ready;
    assign w_op      = op_e'(cmd_op);
    assign cmd_ready = (r_state != ST_STEP);
    assign busy      = (r_state != ST_IDLE);
    assign q         = r_q;
    assign wrap      = r_wrap;
    assign done      = r_done;
    assign err       = r_err;

    johnson_prescaler u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_pclr),
        .en   (r_state == ST_RUN),
        .div  (r_div),
        .tick (w_tick),
        .pcnt (w_pcnt)
    );

    // Next-state, command decode and advance/wrap/done bookkeeping.
    always_comb begin
        // NOTE: every signal gets a default first so no latch is inferred.
        w_state_nxt = r_state;
        w_q_nxt     = r_q;
        w_dir_nxt   = r_dir;
        w_div_nxt   = r_div;
        w_rot_nxt   = r_rot_left;
        w_err_nxt   = r_err;
        w_wrap_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        w_advance   = 1'b0;
        w_pclr      = (r_state != ST_RUN);   // prescaler parked outside RUN

        unique case (r_state)
            ST_IDLE: begin
                if (w_acc) begin
                    case (w_op)
                        OP_START: begin
                            w_rot_nxt   = cmd_arg;
                            w_state_nxt = ST_RUN;
                        end
                        OP_STEP:    w_state_nxt = ST_STEP;
                        OP_SET_DIV: w_div_nxt   = cmd_arg;
                        OP_SET_DIR: w_dir_nxt   = cmd_arg[0];
                        OP_CLEAR:   w_q_nxt     = '0;
                        OP_RSVD:    w_err_nxt   = 1'b1;
                        default: ;  // NOP, and STOP while already idle
                    endcase
                end
            end

            ST_RUN: begin
                w_advance = w_tick;
                if (w_acc) begin
                    case (w_op)
                        // START/STOP beat a coincident tick.
                        OP_START: begin
                            w_rot_nxt = cmd_arg;
                            w_pclr    = 1'b1;
                            w_advance = 1'b0;
                        end
                        OP_STOP: begin
                            w_state_nxt = ST_IDLE;
                            w_pclr      = 1'b1;
                            w_advance   = 1'b0;
                        end
                        OP_SET_DIV: begin
                            w_div_nxt = cmd_arg;
                            if (w_pcnt > cmd_arg) w_pclr = 1'b1;
                        end
                        OP_SET_DIR: w_dir_nxt = cmd_arg[0];
                        OP_CLEAR, OP_STEP, OP_RSVD: w_err_nxt = 1'b1;
                        default: ;
                    endcase
                end
            end

            ST_STEP: begin
                w_advance   = 1'b1;
                w_state_nxt = ST_IDLE;
            end

            default: w_state_nxt = ST_IDLE;
        endcase

        if (w_advance) begin
            w_q_nxt = step_q(r_q, r_dir);
            if (w_q_nxt == '0) begin
                w_wrap_nxt = 1'b1;
                // Only counted runs consume rotations; a step never completes one.
                if (r_state == ST_RUN && r_rot_left != '0) begin
                    w_rot_nxt = r_rot_left - ROT_W'(1);
                    if (r_rot_left == ROT_W'(1)) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_q        <= '0;
            r_dir      <= 1'b0;
            r_div      <= '0;
            r_rot_left <= '0;
            r_wrap     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_q        <= w_q_nxt;
            r_dir      <= w_dir_nxt;
            r_div      <= w_div_nxt;
            r_rot_left <= w_rot_nxt;
            r_wrap     <= w_wrap_nxt;
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
        end
    end

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// Directed bench for johnson_seq_ctrl (WIDTH=8) with hand-computed expectations.
module tb_johnson_seq_ctrl;
    import johnson_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_arg;
    logic [7:0] q;
    logic       busy;
    logic       wrap;
    logic       done;
    logic       err;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    johnson_seq_ctrl #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_arg   (cmd_arg),
        .q         (q),
        .busy      (busy),
        .wrap      (wrap),
        .done      (done),
        .err       (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Present one command for exactly one edge; return 1ns after that edge.
    task automatic send(input logic [2:0] op, input logic [7:0] arg);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
        cmd_arg   = 8'h00;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] exp_seq [16] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                                 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00};

    initial begin
        int wrap_cnt;
        int done_cnt;
        int first_wrap;
        int second_wrap;

        rst = 1'b1; cmd_valid = 1'b0; cmd_op = OP_NOP; cmd_arg = 8'h00;
        cyc(); cyc();
        check("rst_q",     q,         0);
        check("rst_busy",  busy,      0);
        check("rst_ready", cmd_ready, 1);
        check("rst_err",   err,       0);
        check("rst_wrap",  wrap,      0);
        check("rst_done",  done,      0);
        @(negedge clk); rst = 1'b0;

        // Counted run of one rotation, div=0, up.
        send(OP_START, 8'd1);
        check("run1_q0",    q,    8'h00);
        check("run1_busy",  busy, 1);
        for (int i = 0; i < 16; i++) begin
            cyc();
            check($sformatf("run1_q%0d", i + 1), q, exp_seq[i]);
            check($sformatf("run1_wrap%0d", i + 1), wrap, (i == 15) ? 1 : 0);
            check($sformatf("run1_done%0d", i + 1), done, (i == 15) ? 1 : 0);
        end
        check("run1_busy_end", busy, 0);
        cyc();
        check("run1_wrap_1cyc", wrap, 0);
        check("run1_done_1cyc", done, 0);
        check("run1_q_hold",    q,    8'h00);

        // STOP in IDLE is a no-op; then a down step from 00.
        send(OP_STOP, 8'd0);
        check("idle_stop_busy", busy, 0);
        send(OP_SET_DIR, 8'd1);
        send(OP_STEP, 8'd0);
        check("step_ready0", cmd_ready, 0);
        check("step_busy",   busy,      1);
        check("step_q_pre",  q,         8'h00);
        cyc();
        check("step_q",      q,         8'h80);
        check("step_ready1", cmd_ready, 1);
        check("step_busy0",  busy,      0);
        check("step_wrap",   wrap,      0);

        // CLEAR in IDLE: q to zero without a wrap pulse.
        send(OP_SET_DIR, 8'd0);
        send(OP_CLEAR, 8'd0);
        check("clr_q",    q,    8'h00);
        check("clr_wrap", wrap, 0);

        // STOP coincident with a tick at q=0F.
        send(OP_START, 8'd0);
        cyc(); cyc(); cyc(); cyc();
        check("stop_pre_q", q, 8'h0F);
        send(OP_STOP, 8'd0);
        check("stop_q",    q,    8'h0F);
        check("stop_busy", busy, 0);
        cyc();
        check("stop_q_hold", q, 8'h0F);

        // CLEAR in RUN: sticky err, advance continues.
        send(OP_START, 8'd0);
        check("err_pre", err, 0);
        send(OP_CLEAR, 8'd0);
        check("err_set",  err,  1);
        check("err_q1",   q,    8'h1F);
        check("err_busy", busy, 1);
        cyc();
        check("err_sticky", err, 1);
        check("err_q2",     q,   8'h3F);

        // Asynchronous reset mid-run at q=3F.
        #2 rst = 1'b1;
        #1;
        check("arst_q",    q,    8'h00);
        check("arst_busy", busy, 0);
        check("arst_err",  err,  0);
        check("arst_done", done, 0);
        cyc();
        check("arst_done2", done, 0);
        check("arst_wrap2", wrap, 0);
        @(negedge clk); rst = 1'b0;

        // div=3 free run: advance every 4 cycles, wrap every 64, no done.
        send(OP_SET_DIV, 8'd3);
        send(OP_START, 8'd0);
        wrap_cnt = 0; done_cnt = 0; first_wrap = -1; second_wrap = -1;
        for (int k = 1; k <= 130; k++) begin
            cyc();
            if (k == 3) check("div_q_k3", q, 8'h00);
            if (k == 4) check("div_q_k4", q, 8'h01);
            if (k == 7) check("div_q_k7", q, 8'h01);
            if (k == 8) check("div_q_k8", q, 8'h03);
            if (wrap) begin
                wrap_cnt++;
                if (first_wrap < 0) first_wrap = k;
                else if (second_wrap < 0) second_wrap = k;
            end
            if (done) done_cnt++;
        end
        check("div_first_wrap",  first_wrap,  64);
        check("div_second_wrap", second_wrap, 128);
        check("div_wrap_cnt",    wrap_cnt,    2);
        check("div_done_cnt",    done_cnt,    0);

        // Shrinking div below the current count restarts the prescaler.
        send(OP_SET_DIV, 8'd1);
        cyc();
        check("sdiv_q_k132", q, 8'h00);
        cyc();
        check("sdiv_q_k133", q, 8'h01);
        cyc();
        check("sdiv_q_k134", q, 8'h01);
        cyc();
        check("sdiv_q_k135", q, 8'h03);
        send(OP_STOP, 8'd0);

        // Reserved opcode in IDLE sets err.
        send(OP_RSVD, 8'd0);
        check("rsvd_err",  err,  1);
        check("rsvd_busy", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/johnson_seq_ctrl.md
JOHNSON_SEQ_CTRL -- requirements
Module: johnson_seq_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, setting the Johnson register width (legal range 2..8).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port cmd_valid, input, 1 bit: the command is presented.
REQ-005 The block SHALL have port cmd_ready, output, 1 bit: the command can be accepted; accept when cmd_valid && cmd_ready at a rising edge.
REQ-006 The block SHALL have port cmd_op, input, 3 bits: opcode (0 NOP, 1 START, 2 STOP, 3 STEP, 4 SET_DIV, 5 SET_DIR, 6 CLEAR, 7 reserved).
REQ-007 The block SHALL have port cmd_arg, input, 8 bits: opcode argument.
REQ-008 The block SHALL have port q, output, WIDTH bits: the Johnson counter value.
REQ-009 The block SHALL have port busy, output, 1 bit: high while state is RUN or STEP.
REQ-010 The block SHALL have port wrap, output, 1 bit: one-cycle pulse on an advance into all-zero.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle pulse when a counted run completes.
REQ-012 The block SHALL have port err, output, 1 bit: sticky illegal-command flag, cleared only by reset.

Function
REQ-013 The FSM SHALL have states IDLE, RUN and STEP; cmd_ready SHALL be 1 in IDLE and RUN, and 0 in STEP.
REQ-014 An up-direction advance SHALL load q with {q[WIDTH-2:0], ~q[WIDTH-1]}; a down-direction advance SHALL load q with {~q[0], q[WIDTH-1:1]}; one rotation SHALL be 2*WIDTH advances.
REQ-015 The prescaler pcnt (8 bits) SHALL count 0..div in RUN; an advance SHALL occur at the edge where pcnt==div, pcnt then returning to 0, so that advances occur every div+1 cycles.
REQ-016 START accepted in IDLE SHALL set rot_left=cmd_arg, pcnt=0 and state=RUN, with the first advance at edge E0+div+1, where E0 is the acceptance edge; q SHALL be kept.
REQ-017 cmd_arg=0 on START SHALL mean free-run: wrap pulses normally, done never fires.
REQ-018 START accepted in RUN SHALL reload rot_left and clear pcnt, with no advance at that edge.
REQ-019 wrap SHALL assert in the cycle after an advance produced q==0.
REQ-020 In a counted run, each wrap SHALL decrement rot_left; the wrap that takes rot_left to 0 SHALL also pulse done in the same cycle and return the FSM to IDLE.
REQ-021 STOP SHALL move the FSM to IDLE at the acceptance edge, preventing any advance at that edge; q SHALL hold and pcnt SHALL clear. STOP in IDLE SHALL be a no-op.
REQ-022 STEP in IDLE SHALL enter STEP; exactly one advance SHALL occur at the next edge, then the FSM SHALL return to IDLE; wrap and done rules SHALL apply as in RUN, except that done SHALL never fire.
REQ-023 SET_DIV SHALL set div=cmd_arg in any state; in RUN, if pcnt exceeds the new div, pcnt SHALL clear.
REQ-024 SET_DIR SHALL set dir=cmd_arg[0] (0 up, 1 down) in any state; it SHALL take effect from the next advance.
REQ-025 CLEAR in IDLE SHALL set q=0 without pulsing wrap.
REQ-026 CLEAR in RUN, STEP in RUN, and opcode 7 in any state SHALL set err, and SHALL otherwise be ignored.
REQ-027 NOP SHALL have no effect.
REQ-028 Simultaneous events SHALL resolve as follows: when a command acceptance and a tick coincide in RUN, STOP and START SHALL win (no advance); all other opcodes SHALL let the advance proceed.

Reset
REQ-029 While rst is high, the block SHALL force q=0, state=IDLE, dir=0, div=0, pcnt=0, rot_left=0, wrap=0, done=0 and err=0, giving busy=0 and cmd_ready=1.
REQ-030 Reset asserted mid-RUN SHALL abort the run immediately, with no done pulse.

Structure
REQ-031 Package johnson_pkg SHALL hold the opcode enum, the FSM state enum, and the PCNT_W=8 and ROT_W=8 constants.
REQ-032 The prescaler SHALL be sub-module johnson_prescaler, with inputs clr, en and div, and output tick.

Verification
REQ-033 Scenario: WIDTH=8, div=0, dir=0, START arg=1 -> q steps 01,03,07,0F,1F,3F,7F,FF,FE,FC,F8,F0,E0,C0,80,00 on consecutive cycles; wrap and done pulse together; busy falls.
REQ-034 Scenario: SET_DIV 3, START arg=0 -> q advances every 4 cycles; wrap every 64 cycles; done never pulses.
REQ-035 Scenario: from q=00, SET_DIR 1, STEP -> q=80 after 1 cycle; cmd_ready is 0 for exactly that cycle.
REQ-036 Scenario: in RUN with q=0F, issue STOP coincident with a tick -> q remains 0F; busy=0 at the next cycle.
REQ-037 Scenario: in RUN, issue CLEAR -> err=1 and stays 1; q continues advancing.
REQ-038 Scenario: in RUN at q=3F, assert rst -> q=00, busy=0 and err=0 immediately, with no done pulse.
